mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of both masters and the memory port.
REQ-002 Parameter DATA_W, default 32, data width of both masters and the memory port.
REQ-003 Parameter MEM_LAT, default 1, legal range 1..4, read latency in cycles from mem_en to valid mem_rdata.
REQ-004 Port clk, in, 1, the single clock; all state updates on the rising edge.
REQ-005 Port rst, in, 1, asynchronous, active-high reset.
REQ-006 Ports m0_req / m1_req, in, 1 each, master N requests one access.
REQ-007 Ports m0_we / m1_we, in, 1 each, 1 = write, 0 = read.
REQ-008 Ports m0_addr / m1_addr, in, ADDR_W each, access address.
REQ-009 Ports m0_wdata / m1_wdata, in, DATA_W each, write data.
REQ-010 Ports m0_gnt / m1_gnt, out, 1 each, one-cycle pulse marking that master N's access is issued.
REQ-011 Ports m0_rvalid / m1_rvalid, out, 1 each, one-cycle pulse marking that read data is valid.
REQ-012 Port rdata, out, DATA_W, read data shared by both masters; valid only while an rvalid is high.
REQ-013 Ports mem_en / mem_we, out, 1 each, memory strobe and write enable.
REQ-014 Ports mem_addr / mem_wdata, out, ADDR_W / DATA_W, memory address and write data.
REQ-015 Port mem_rdata, in, DATA_W, memory read data.
REQ-016 Port busy, out, 1, high in every state except IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and WAIT.
- IDLE -> ACCESS when any request is sampled.
- ACCESS -> IDLE for a write.
- ACCESS -> WAIT for a read.
- WAIT -> IDLE after the last latency cycle.
REQ-018 In IDLE, the winner's we/addr/wdata and index SHALL be latched at the edge where requests are sampled; any later change or req deassertion SHALL have no effect on that access.
REQ-019 In ACCESS only, the block SHALL drive mem_en=1, drive mem_we/addr/wdata from the latched fields and pulse the winner's gnt; req-to-gnt latency SHALL be exactly 1 cycle.
REQ-020 A read SHALL pulse the winner's rvalid exactly MEM_LAT cycles after its ACCESS cycle, with rdata = mem_rdata in that cycle; a write SHALL never produce rvalid.
REQ-021 Only one transaction SHALL be outstanding; requests arriving in ACCESS or WAIT SHALL wait until IDLE.
REQ-022 A requester SHALL hold req until its gnt; the gnt cycle consumes the request.
REQ-023 The WAIT down-counter SHALL be ceil(log2(MEM_LAT+1)) bits wide, load MEM_LAT-1 on ACCESS->WAIT and never underflow.
REQ-024 Outside ACCESS, mem_en, mem_we and both gnt outputs SHALL be 0; mem_addr and mem_wdata SHALL hold their last value.

Reset
REQ-025 rst SHALL immediately force state IDLE, all gnt, rvalid, mem_en and mem_we to 0, counter 0, latched fields 0 and the round-robin pointer "last = m1".
REQ-026 Reset asserted during ACCESS or WAIT SHALL abort the transaction; no rvalid for it SHALL ever appear.

Configuration
REQ-027 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be arbitrated round-robin: the master not granted last wins, and the pointer updates on every gnt.
REQ-028 Without MEM_ARB_RR_EN, m0 SHALL always win simultaneous requests, and no pointer register SHALL exist.

Structure
REQ-029 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/WAIT), the master index constants M0=0 and M1=1, and the MEM_LAT bounds.
REQ-030 The winner selection SHALL live in sub-module arb_pick2, covering both fixed-priority and round-robin variants.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Reset, then m0 reads 0x10 with MEM_LAT=1 and memory returning 0xDEADBEEF -> m0_gnt at cycle 1, m0_rvalid at cycle 2 with rdata=0xDEADBEEF.
- m1 writes 0xA5A5A5A5 to 0x20 -> one mem_en/mem_we cycle with addr 0x20, m1_gnt pulse, no rvalid, busy low the next cycle.
- Both masters request every cycle, writes, MEM_ARB_RR_EN defined -> grants alternate m0, m1, m0, m1; undefined -> m0 every grant, m1 starved.
- MEM_LAT=4 read by m0, m1 requests during WAIT -> m0_rvalid 4 cycles after ACCESS, m1_gnt no earlier than the following ACCESS.
- rst pulsed during WAIT of an m1 read -> outputs 0 immediately, no m1_rvalid, next request granted normally.
- m0 changes addr from 0x30 to 0x40 after sampling but before gnt -> mem_addr=0x30.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter.
//   state_t      : arbiter FSM states (IDLE / ACCESS / WAIT)
//   M0, M1       : master index encodings
//   MEM_LAT_MIN/MAX : legal read-latency range
//   cnt_width()  : width of the WAIT down-counter for a given latency
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  // ceil(log2(lat+1)) bits hold every value 0..lat
  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational winner selection between two requesters.
//   RR_EN = 0 : fixed priority, req0 wins ties; last is ignored.
//   RR_EN = 1 : round robin, the master not granted last wins ties.
// Ports:
//   req0, req1 : requests
//   last       : index of the master granted most recently
//   any_c      : at least one request present
//   winner_c   : index of the selected master (M0 when nobody requests)
module arb_pick2
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic any_c,
  output logic winner_c
);

  logic prefer1;

  // m1 is preferred on a tie only in round-robin mode after an m0 grant
  assign prefer1  = RR_EN & (last == M0);
  assign any_c    = req0 | req1;
  assign winner_c = (req1 & (~req0 | prefer1)) ? M1 : M0;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port memory with a
// fixed read latency. One transaction outstanding at a time.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise m0 always wins ties.
// Ports:
//   clk, rst (async, active high)
//   m0_/m1_ req, we, addr, wdata : master request side
//   m0_/m1_ gnt                  : one-cycle pulse in the ACCESS cycle
//   m0_/m1_ rvalid, rdata        : read return, MEM_LAT cycles after ACCESS
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata : memory port
//   busy                         : high whenever the FSM is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  logic               sel_idx;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  logic               last;
  logic               any_c;
  logic               winner_c;
  logic               take_c;
  logic               win_we_c;

  logic               gnt0_nx, gnt1_nx, rv0_nx, rv1_nx, en_nx, we_nx, busy_nx;

  // Round-robin pointer exists only in the round-robin build
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last <= M1;
    else if (take_c) last <= winner_c;
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last = M1;
`endif

  arb_pick2 #(
    .RR_EN (RR_EN)
  ) u_pick (
    .req0     (m0_req),
    .req1     (m1_req),
    .last     (last),
    .any_c    (any_c),
    .winner_c (winner_c)
  );

  assign take_c   = (state == IDLE) & any_c;
  assign win_we_c = (winner_c == M1) ? m1_we : m0_we;

  // Memory address/data come straight from the fields latched at sampling,
  // so they hold their value outside ACCESS
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;

  // Read data is valid in the rvalid cycle itself, so it is a pass-through
  assign rdata = mem_rdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (any_c) state_nx = ACCESS;
      end
      ACCESS: begin
        if (sel_we) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
          cnt_nx   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    en_nx   = take_c;
    we_nx   = take_c & win_we_c;
    gnt0_nx = take_c & (winner_c == M0);
    gnt1_nx = take_c & (winner_c == M1);
    // rvalid lands in the WAIT cycle whose counter reads zero
    rv0_nx  = (state_nx == WAIT) & (cnt_nx == '0) & (sel_idx == M0);
    rv1_nx  = (state_nx == WAIT) & (cnt_nx == '0) & (sel_idx == M1);
    busy_nx = (state_nx != IDLE);
  end

  // Winner fields latched at the sampling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_idx   <= M0;
      sel_we    <= 1'b0;
      sel_addr  <= '0;
      sel_wdata <= '0;
    end else if (take_c) begin
      sel_idx   <= winner_c;
      sel_we    <= win_we_c;
      sel_addr  <= (winner_c == M1) ? m1_addr  : m0_addr;
      sel_wdata <= (winner_c == M1) ? m1_wdata : m0_wdata;
    end
  end

  // Registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      m0_gnt    <= gnt0_nx;
      m1_gnt    <= gnt1_nx;
      m0_rvalid <= rv0_nx;
      m1_rvalid <= rv1_nx;
      mem_en    <= en_nx;
      mem_we    <= we_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance a uses MEM_LAT=1,
// instance b uses MEM_LAT=4; both share the same stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(a_m0_gnt), .m1_gnt(a_m1_gnt),
    .m0_rvalid(a_m0_rvalid), .m1_rvalid(a_m1_rvalid), .rdata(a_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt),
    .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid), .rdata(b_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) tick();
    check("rst_busy",   32'(a_busy),    32'd0);
    check("rst_gnt0",   32'(a_m0_gnt),  32'd0);
    check("rst_mem_en", 32'(a_mem_en),  32'd0);
    check("rst_addr",   a_mem_addr,     32'h0);
    check("rst_b_busy", 32'(b_busy),    32'd0);
    rst = 1'b0;

    // ---- m0 read of 0x10, MEM_LAT=1 ----
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_gnt0",    32'(a_m0_gnt),  32'd1);
    check("rd_gnt1",    32'(a_m1_gnt),  32'd0);
    check("rd_en",      32'(a_mem_en),  32'd1);
    check("rd_we",      32'(a_mem_we),  32'd0);
    check("rd_addr",    a_mem_addr,     32'h10);
    check("rd_rv_early",32'(a_m0_rvalid), 32'd0);
    m0_req = 1'b0;
    tick();
    check("rd_rvalid",  32'(a_m0_rvalid), 32'd1);
    check("rd_rv1",     32'(a_m1_rvalid), 32'd0);
    check("rd_rdata",   a_rdata,        32'hDEADBEEF);
    check("rd_en_off",  32'(a_mem_en),  32'd0);
    check("rd_gnt_off", 32'(a_m0_gnt),  32'd0);
    tick();
    check("rd_rv_off",  32'(a_m0_rvalid), 32'd0);
    check("rd_idle",    32'(a_busy),    32'd0);
    check("rd_addr_hold", a_mem_addr,   32'h10);

    // ---- m1 write 0xA5A5A5A5 to 0x20 ----
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
    tick();
    check("wr_gnt1",    32'(a_m1_gnt),  32'd1);
    check("wr_gnt0",    32'(a_m0_gnt),  32'd0);
    check("wr_en",      32'(a_mem_en),  32'd1);
    check("wr_we",      32'(a_mem_we),  32'd1);
    check("wr_addr",    a_mem_addr,     32'h20);
    check("wr_wdata",   a_mem_wdata,    32'hA5A5A5A5);
    m1_req = 1'b0;
    tick();
    check("wr_busy",    32'(a_busy),    32'd0);
    check("wr_en_off",  32'(a_mem_en),  32'd0);
    check("wr_we_off",  32'(a_mem_we),  32'd0);
    check("wr_rv1",     32'(a_m1_rvalid), 32'd0);
    check("wr_wd_hold", a_mem_wdata,    32'hA5A5A5A5);
    tick();
    check("wr_rv1_late",32'(a_m1_rvalid), 32'd0);

    // ---- both masters write every cycle ----
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h2;
    for (int g = 0; g < 4; g++) begin
      logic exp1;
`ifdef MEM_ARB_RR_EN
      exp1 = (g % 2) == 1;
`else
      exp1 = 1'b0;
`endif
      tick();
      check("both_gnt0", 32'(a_m0_gnt), 32'(!exp1));
      check("both_gnt1", 32'(a_m1_gnt), 32'(exp1));
      check("both_addr", a_mem_addr,    exp1 ? 32'h200 : 32'h100);
      tick();
      check("both_idle", 32'(a_busy),   32'd0);
    end
    m0_req = 1'b0; m1_req = 1'b0;

    // ---- MEM_LAT=4 read by m0, m1 requests during WAIT ----
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44; mem_rdata = 32'h12345678;
    tick();
    check("l4_gnt0",    32'(b_m0_gnt),  32'd1);
    check("l4_addr",    b_mem_addr,     32'h44);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h50; m1_wdata = 32'h55;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("l4_wait_rv", 32'(b_m0_rvalid), 32'd0);
      check("l4_wait_g1", 32'(b_m1_gnt),    32'd0);
      check("l4_wait_bz", 32'(b_busy),      32'd1);
    end
    tick();
    check("l4_rvalid",  32'(b_m0_rvalid), 32'd1);
    check("l4_rdata",   b_rdata,        32'h12345678);
    check("l4_g1_rv",   32'(b_m1_gnt),  32'd0);
    tick();
    check("l4_idle_rv", 32'(b_m0_rvalid), 32'd0);
    check("l4_idle_g1", 32'(b_m1_gnt),  32'd0);
    check("l4_idle_bz", 32'(b_busy),    32'd0);
    tick();
    check("l4_gnt1",    32'(b_m1_gnt),  32'd1);
    check("l4_addr1",   b_mem_addr,     32'h50);
    check("l4_we1",     32'(b_mem_we),  32'd1);
    m1_req = 1'b0;

    // ---- reset during WAIT of an m1 read ----
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h60; m1_wdata = 32'h0;
    tick();
    check("ab_gnt1",    32'(b_m1_gnt),  32'd1);
    m1_req = 1'b0;
    tick();
    check("ab_wait",    32'(b_busy),    32'd1);
    rst = 1'b1;
    #1;
    check("ab_busy",    32'(b_busy),    32'd0);
    check("ab_en",      32'(b_mem_en),  32'd0);
    check("ab_addr",    b_mem_addr,     32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("ab_no_rv1", 32'(b_m1_rvalid), 32'd0);
    end
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h70; m1_wdata = 32'h77;
    tick();
    check("ab_regnt",   32'(b_m1_gnt),  32'd1);
    check("ab_readdr",  b_mem_addr,     32'h70);
    check("ab_rewd",    b_mem_wdata,    32'h77);
    m1_req = 1'b0;

    // ---- request fields change after sampling ----
    do_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wdata = 32'h77;
    @(posedge clk);
    #1;
    m0_addr = 32'h40; m0_wdata = 32'h88; m0_req = 1'b0;
    check("lat_gnt0",   32'(a_m0_gnt),  32'd1);
    check("lat_addr",   a_mem_addr,     32'h30);
    check("lat_wdata",  a_mem_wdata,    32'h77);
    tick();
    check("lat_hold",   a_mem_addr,     32'h30);
    check("lat_idle",   32'(a_busy),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
